// File: rtl/md5_pkg.sv
// Shared types and widths for the MD5 brute-force controller and its tracker.
package md5_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int MD5_DIGEST_W   = 128;
    localparam int MD5_MSG_W      = 128;
    localparam int PIPE_DEPTH_DEF = 64;
    localparam int CNT_W_DEF      = 64;
    localparam int INFLIGHT_W_DEF = 7;

endpackage

// File: rtl/md5_crack_ctrl_if.sv
// Host and pipeline signals of one crack controller; master is the controller side.
interface md5_crack_ctrl_if
    import md5_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);

    logic                    start;
    logic                    abort;
    logic [CNT_W-1:0]        range_lo;
    logic [CNT_W-1:0]        range_hi;
    logic [MD5_DIGEST_W-1:0] target;
    logic [MD5_MSG_W-1:0]    message;
    logic                    new_message;
    logic [MD5_DIGEST_W-1:0] digest;
    logic                    valid;
    logic [MD5_MSG_W-1:0]    value;
    logic                    busy;
    logic                    done;
    logic                    found;
    logic [MD5_MSG_W-1:0]    found_value;
    logic [CNT_W:0]          issued;

    modport master (
        input  start, abort, range_lo, range_hi, target, digest, valid, value,
        output message, new_message, busy, done, found, found_value, issued
    );

    modport slave (
        output start, abort, range_lo, range_hi, target, digest, valid, value,
        input  message, new_message, busy, done, found, found_value, issued
    );

endinterface

// File: rtl/md5_inflight_tracker.sv
// Counts candidates inside the MD5 pipeline; a result with nothing in flight is stale and not counted.
module md5_inflight_tracker #(
    parameter int PIPE_DEPTH = 64,
    parameter int INFLIGHT_W = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inc,
    input  logic                  dec,
    output logic [INFLIGHT_W-1:0] count,
    output logic                  empty
);

    logic dec_ok;

    assign empty  = (count == '0);
    assign dec_ok = dec && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && !dec_ok) begin
            count <= count + INFLIGHT_W'(1);
        end else if (!inc && dec_ok) begin
            count <= count - INFLIGHT_W'(1);
        end
    end

    assert property (@(posedge clk) disable iff (rst)
        !(inc && !dec_ok && (count == INFLIGHT_W'(PIPE_DEPTH))));

endmodule

// File: rtl/md5_crack_ctrl.sv
// Brute-force sequencer: issues one candidate per cycle, latches the first digest match, drains, reports done.
module md5_crack_ctrl
    import md5_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEF,
    parameter int PIPE_DEPTH = PIPE_DEPTH_DEF,
    parameter int INFLIGHT_W = INFLIGHT_W_DEF
) (
    input logic            clk,
    input logic            rst,
    md5_crack_ctrl_if.master bus
);

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        hi;
    logic [MD5_DIGEST_W-1:0] tgt;
    logic                    found_r;
    logic [MD5_MSG_W-1:0]    found_value_r;
    logic [CNT_W:0]          issued_r;
    logic [MD5_MSG_W-1:0]    message_p1;
    logic                    new_message_p1;
    logic [INFLIGHT_W-1:0]   inflight;
    logic                    empty;
    logic                    start_ok;
    logic                    match;
    logic                    issue_go;
    logic                    last;

    md5_inflight_tracker #(
        .PIPE_DEPTH (PIPE_DEPTH),
        .INFLIGHT_W (INFLIGHT_W)
    ) u_trk (
        .clk   (clk),
        .rst   (rst),
        .inc   (new_message_p1),
        .dec   (bus.valid),
        .count (inflight),
        .empty (empty)
    );

    assign start_ok = bus.start && ((state == ST_IDLE) || (state == ST_DONE));
    // Results arriving with nothing in flight predate the current run and never match.
    assign match    = bus.valid && !empty && (bus.digest == tgt) && !found_r
                      && ((state == ST_ISSUE) || (state == ST_DRAIN));
    assign issue_go = (state == ST_ISSUE) && !bus.abort && !match;
    assign last     = (cnt == hi);

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (bus.start) state_nxt = (bus.range_lo > bus.range_hi) ? ST_DONE : ST_ISSUE;
            end
            ST_ISSUE: begin
                if (bus.abort || match || last) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                // The registered strobe is not yet counted, so it must also be quiet.
                if ((inflight == '0) && !bus.valid && !new_message_p1) state_nxt = ST_DONE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt            <= '0;
            hi             <= '0;
            tgt            <= '0;
            found_r        <= 1'b0;
            found_value_r  <= '0;
            issued_r       <= '0;
            message_p1     <= '0;
            new_message_p1 <= 1'b0;
        end else begin
            new_message_p1 <= issue_go;
            if (start_ok) begin
                cnt           <= bus.range_lo;
                hi            <= bus.range_hi;
                tgt           <= bus.target;
                found_r       <= 1'b0;
                found_value_r <= '0;
                issued_r      <= '0;
            end
            // Compare against hi before incrementing so an all-ones bound never wraps.
            if (issue_go) begin
                message_p1 <= MD5_MSG_W'(cnt);
                issued_r   <= issued_r + (CNT_W + 1)'(1);
                if (!last) cnt <= cnt + CNT_W'(1);
            end
            if (match) begin
                found_r       <= 1'b1;
                found_value_r <= bus.value;
            end
        end
    end

    assign bus.message     = message_p1;
    assign bus.new_message = new_message_p1;
    assign bus.busy        = (state == ST_ISSUE) || (state == ST_DRAIN);
    assign bus.done        = (state == ST_DONE);
    assign bus.found       = found_r;
    assign bus.found_value = found_value_r;
    assign bus.issued      = issued_r;

endmodule

// File: tb/tb_md5_crack_ctrl.sv
// Bench for md5_crack_ctrl: 64-deep pipeline stub (digest = ~value), queue scoreboard, reference model.
// Timing model: with start high in cycle c, done is first seen in cycle c + issued + PIPE_DEPTH + 3
// (c + 1 for an empty range), i.e. N + PIPE_DEPTH + 3 cycles for N candidates without a match.
module tb_md5_crack_ctrl;
    import md5_pkg::*;

    localparam int CNT_W = 64;
    localparam int DEPTH = 64;
    localparam logic [127:0] MISS = {27'd0, 1'b1, 100'd0};

    typedef struct {
        logic         found;
        logic [127:0] fv;
        logic [64:0]  issued;
        longint       done_cyc;
    } res_t;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    longint cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    md5_crack_ctrl_if #(.CNT_W(CNT_W)) bus ();

    md5_crack_ctrl #(
        .CNT_W      (CNT_W),
        .PIPE_DEPTH (DEPTH),
        .INFLIGHT_W (7)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Pipeline stub: fixed latency, not affected by the controller reset.
    logic [DEPTH-1:0] vsr = '0;
    logic [127:0]     msr [DEPTH];

    always @(posedge clk) begin
        vsr    <= {vsr[DEPTH-2:0], bus.new_message};
        msr[0] <= bus.message;
        for (int i = 1; i < DEPTH; i++) msr[i] <= msr[i-1];
    end

    assign bus.valid  = vsr[DEPTH-1];
    assign bus.value  = msr[DEPTH-1];
    assign bus.digest = ~msr[DEPTH-1];

    logic [127:0] msg_q [$];
    res_t         res_q [$];
    int           checks   = 0;
    int           failures = 0;
    bit           armed    = 1'b0;
    res_t         mon_r;
    logic [127:0] mon_m;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Monitor: compares every issued candidate and every completed run against the scoreboard.
    always @(negedge clk) begin
        if (bus.new_message) begin
            if (msg_q.size() == 0) begin
                check("unexpected_new_message", bus.message, '1);
            end else begin
                mon_m = msg_q.pop_front();
                check("message", bus.message, mon_m);
            end
        end
        if (bus.done && armed) begin
            armed = 1'b0;
            if (res_q.size() == 0) begin
                check("unexpected_done", 128'(cyc), '1);
            end else begin
                mon_r = res_q.pop_front();
                check("done_cycle", 128'(cyc), 128'(mon_r.done_cyc));
                check("found", 128'(bus.found), 128'(mon_r.found));
                check("found_value", bus.found_value, mon_r.fv);
                check("issued", 128'(bus.issued), 128'(mon_r.issued));
                check("busy_at_done", 128'(bus.busy), 128'd0);
                check("inflight_at_done", 128'(dut.u_trk.count), 128'd0);
            end
        end
        if (bus.start) armed = 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: candidate lo+m returns PIPE_DEPTH+1 issue slots after it was issued.
    task automatic launch(input logic [63:0] lo, input logic [63:0] hi, input logic [127:0] x,
                          input int abort_at, input bit push_res, output longint sc);
        logic [64:0]  n, iss, m;
        logic [127:0] lo_w, hi_w;
        bit           hit;
        res_t         r;
        lo_w = {64'd0, lo};
        hi_w = {64'd0, hi};
        n    = (lo > hi) ? 65'd0 : ({1'b0, hi} - {1'b0, lo} + 65'd1);
        hit  = (n != 65'd0) && (x >= lo_w) && (x <= hi_w);
        m    = hit ? 65'(x - lo_w) : 65'd0;
        iss  = n;
        if (hit && (m + 65'(DEPTH + 1) < iss)) iss = m + 65'(DEPTH + 1);
        if (abort_at >= 0 && 65'(abort_at) < iss) iss = 65'(abort_at);
        for (longint i = 0; i < longint'(iss); i++) msg_q.push_back(lo_w + 128'(i));
        r.found  = hit && (m < iss);
        r.fv     = r.found ? x : 128'd0;
        r.issued = iss;
        tick();
        bus.range_lo = lo;
        bus.range_hi = hi;
        bus.target   = ~x;
        bus.start    = 1'b1;
        sc           = cyc;
        r.done_cyc   = (n == 65'd0) ? sc + 1 : sc + longint'(iss) + DEPTH + 3;
        if (push_res) res_q.push_back(r);
        tick();
        bus.start = 1'b0;
        if (abort_at >= 0) begin
            repeat (abort_at) tick();
            bus.abort = 1'b1;
            tick();
            bus.abort = 1'b0;
        end
    endtask

    task automatic wait_done(input longint sc);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk);
            if (bus.done && cyc > sc) got = 1'b1;
        end
        if (!got) check("done_timeout", 128'd0, 128'd1);
        repeat (3) tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_message"}, bus.message, 128'd0);
        check({tag, "_new_message"}, 128'(bus.new_message), 128'd0);
        check({tag, "_busy"}, 128'(bus.busy), 128'd0);
        check({tag, "_done"}, 128'(bus.done), 128'd0);
        check({tag, "_found"}, 128'(bus.found), 128'd0);
        check({tag, "_found_value"}, bus.found_value, 128'd0);
        check({tag, "_issued"}, 128'(bus.issued), 128'd0);
        check({tag, "_inflight"}, 128'(dut.u_trk.count), 128'd0);
    endtask

    initial begin
        longint      sc;
        logic [63:0] lo, hi;
        int          len, ab, bad;
        logic [127:0] x;

        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        bus.range_lo = '0;
        bus.range_hi = '0;
        bus.target   = '0;
        rst          = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        tick();
        rst = 1'b0;

        launch(64'd5, 64'd5, 128'd5, -1, 1'b1, sc);              wait_done(sc);
        launch(64'd0, 64'd99, 128'd200, -1, 1'b1, sc);           wait_done(sc);
        launch(64'd0, 64'd999, 128'd10, -1, 1'b1, sc);           wait_done(sc);
        launch(64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF,
               128'd0, -1, 1'b1, sc);                            wait_done(sc);
        launch(64'd7, 64'd3, 128'd5, -1, 1'b1, sc);              wait_done(sc);
        launch(64'd0, 64'd999, MISS, 10, 1'b1, sc);              wait_done(sc);

        for (int t = 0; t < 6; t++) begin
            lo  = {32'($urandom_range(0, 32'hFFFF_FFF0)), 32'($urandom)};
            len = int'($urandom_range(1, 150));
            hi  = lo + 64'(len - 1);
            x   = ($urandom_range(0, 1) == 1) ? {64'd0, lo} + 128'($urandom_range(0, len - 1)) : MISS;
            ab  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, len + 5)) : -1;
            launch(lo, hi, x, ab, 1'b1, sc);
            wait_done(sc);
        end

        // Reset in the middle of a drain; stale results must then be ignored.
        launch(64'd0, 64'd999, MISS, 10, 1'b0, sc);
        repeat (20) tick();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("mid_reset");
        tick();
        rst = 1'b0;
        bad = 0;
        repeat (90) begin
            @(negedge clk);
            if (bus.found || bus.busy || bus.done || bus.new_message ||
                dut.u_trk.count != '0 || bus.issued != '0) bad++;
        end
        check("stale_ignored", 128'(bad), 128'd0);

        launch(64'd20, 64'd24, 128'd22, -1, 1'b1, sc);           wait_done(sc);

        check("msg_queue_empty", 128'(msg_q.size()), 128'd0);
        check("res_queue_empty", 128'(res_q.size()), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/md5_crack_ctrl.md
Name: md5_crack_ctrl

Overview:
- Sequencer that drives the 64-stage MD5 pipeline in brute-force search mode.
- Issues one candidate per cycle from an inclusive counter range and watches the pipeline output stream.
- Latches the first candidate whose digest equals the target, then stops issuing.
- Drains in-flight work and reports done.
- Sits between the host/register interface and the pipeline; one controller per pipeline instance.

Parameters:
- CNT_W, 64, width of the candidate counter and the range bounds (1..128).
- PIPE_DEPTH, 64, pipeline latency in cycles from new_message to valid; sizes the in-flight tracker.
- INFLIGHT_W, 7, in-flight counter width; must hold PIPE_DEPTH.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse; accepted only in IDLE or DONE.
- abort  in  1  stop issuing and drain; ignored in IDLE/DONE.
- range_lo  in  CNT_W  first candidate, sampled on accepted start.
- range_hi  in  CNT_W  last candidate (inclusive), sampled on accepted start.
- target  in  128  digest to match, sampled on accepted start.
- message  out  128  candidate to pipeline = {zeros, cnt}.
- new_message  out  1  candidate-valid strobe to pipeline.
- digest  in  128  pipeline digest.
- valid  in  1  pipeline result valid.
- value  in  128  message associated with digest.
- busy  out  1  high in ISSUE or DRAIN.
- done  out  1  level, high in DONE until next accepted start.
- found  out  1  match latched; meaningful when done=1.
- found_value  out  128  value of first matching result.
- issued  out  CNT_W+1  candidates issued since last start.

Behaviour:
- Reset values:
  - state=IDLE.
  - message=0, new_message=0, busy=0, done=0, found=0, found_value=0, issued=0.
  - inflight=0, cnt=0, target register=0.
- Registered outputs: message and new_message are registered; the candidate appears the cycle after the counter decision.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE/DONE + start:
  - Latch range_lo into cnt, range_hi, and target.
  - Clear found, found_value, issued, done.
  - If range_lo > range_hi, go to DONE next cycle; nothing is issued and found=0.
  - Otherwise go to ISSUE.
- ISSUE, each cycle:
  - Assert new_message with message=cnt; issued += 1.
  - If cnt == range_hi, go to DRAIN. Compare before incrementing; never wrap, so range_hi = all-ones must terminate.
  - Otherwise cnt += 1.
- ISSUE exits early to DRAIN on abort or on a match detected this cycle. No candidate is issued in the exit cycle if abort or match is present.
- Match rule: valid && (digest == target register) && !found. On a match, set found=1 and found_value=value on the next edge. Only the first match is kept; later matches are ignored.
- In-flight tracker:
  - +1 on new_message, -1 on valid; both in the same cycle leaves it unchanged.
  - Must never exceed PIPE_DEPTH or underflow.
  - A valid arriving while inflight==0 (stale data from before start) is ignored for matching.
- DRAIN: no issue. Go to DONE when inflight==0 and no valid is present. Matches still latch during DRAIN if found==0.
- DONE: done=1, busy=0; hold all results until the next start.
- Simultaneous start with abort: start wins in IDLE/DONE. In ISSUE/DRAIN, start is ignored.
- rst mid-operation returns everything to reset values on the next edge. The pipeline may still emit stale valids; the inflight==0 rule discards them.
- Throughput: one candidate per cycle in ISSUE. Total cycles for N candidates with no match is N + PIPE_DEPTH + 2, ±1 for output registers, exact per implementation and documented in the test bench.

Decomposition:
- Package md5_pkg holds:
  - State enum.
  - MD5_DIGEST_W=128, MD5_MSG_W=128.
  - PIPE_DEPTH default.
- One natural sub-module, md5_inflight_tracker: up/down counter with saturation assertions, exposing empty and count.
- The range counter stays inline.

Test Plan:
- Bench pipeline stub: depth 64, digest = ~value.
- Range lo=5, hi=5, target=~128'd5 -> exactly one new_message with message=5; found=1, found_value=5; done asserts about 66 cycles after start; issued=1.
- Range lo=0, hi=99, target=~128'd200 -> 100 consecutive new_message pulses (0..99); found=0; issued=100; done after drain; inflight returns to 0.
- Range lo=0, hi=999, target=~128'd10 -> match observed while still issuing; issuing stops within 1 cycle of the match; found_value=10; issued < 1000; done after drain.
- Range lo=all-ones-1, hi=all-ones (CNT_W=64) -> two issues, no counter wrap, issued=2, reaches DONE.
- lo=7, hi=3 -> no new_message; done within 2 cycles; found=0; issued=0.
- Abort 10 cycles into range 0..999 -> issuing stops at about 10; DONE only after 64 more valids; rst asserted during DRAIN -> all outputs are reset values next cycle and stale valids are ignored.
